// File: rtl/jtframe_sdram_arbiter_pkg.sv
// Shared types and constants for the SDRAM slot arbiter.
//   arb_state_t : sequencer state encoding (IDLE=0, ISSUE=1, WAIT=2)
//   WAIT_W      : width of the per-slot starvation counters
//   WDOG_W      : width of the transfer watchdog
//   MASK_READ   : byte mask driven for reads (no byte written)
package jtframe_sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam int         WAIT_W    = 8;
    localparam int         WDOG_W    = 10;
    localparam logic [1:0] MASK_READ = 2'b11;

endpackage

// File: rtl/jtframe_sdram_arbiter_if.sv
// Bundle of the requester-side and controller-side signals of the arbiter.
//   master : the arbiter (drives grants, done pulses and SDRAM commands)
//   slave  : requesters plus SDRAM controller (drive requests, ack, data_rdy)
interface jtframe_sdram_arbiter_if #(
    parameter int N      = 4,
    parameter int SDRAMW = 22
);
    logic [N-1:0]        slot_req;
    logic [N-1:0]        slot_rnw;
    logic [N*SDRAMW-1:0] slot_addr;
    logic [N*16-1:0]     slot_din;
    logic [N*2-1:0]      slot_wrmask;
    logic [N-1:0]        slot_gnt;
    logic [N-1:0]        slot_done;
    logic [N-1:0]        slot_dst;
    logic                timeout_err;
    logic                sdram_ack;
    logic                sdram_rd;
    logic                sdram_wr;
    logic [SDRAMW-1:0]   sdram_addr;
    logic [15:0]         data_write;
    logic [1:0]          sdram_wrmask;
    logic                data_rdy;
    logic                data_dst;

    modport master (
        input  slot_req, slot_rnw, slot_addr, slot_din, slot_wrmask,
        input  sdram_ack, data_rdy, data_dst,
        output slot_gnt, slot_done, slot_dst, timeout_err,
        output sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask
    );

    modport slave (
        output slot_req, slot_rnw, slot_addr, slot_din, slot_wrmask,
        output sdram_ack, data_rdy, data_dst,
        input  slot_gnt, slot_done, slot_dst, timeout_err,
        input  sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask
    );
endinterface

// File: rtl/jtframe_rr_pick.sv
// Round-robin picker: grants the first requesting slot after the one-hot
// 'last' position, wrapping around.
//   req  : request vector
//   last : one-hot position of the previous winner
//   gnt  : one-hot winner, or 0 when nothing requests
module jtframe_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);

    always_comb begin
        int   lidx;
        logic found;
        gnt   = '0;
        lidx  = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++)
            if (last[k]) lidx = k;
        for (int off = 1; off <= N; off++)
            for (int j = 0; j < N; j++)
                if (!found && j == (lidx + off) % N && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
    end

endmodule

// File: rtl/jtframe_sdram_arbiter.sv
// Shares one SDRAM controller port among N requesters. Slot 0 is preferred,
// slots 1..N-1 are served round-robin, and a slot that has waited STARVE
// cycles overrides slot 0. Each transfer is watchdogged from ack to data_rdy.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester and controller signals (master modport)
//
// state | meaning
// IDLE  | no transfer; arbitrate any pending request
// ISSUE | command strobe high, waiting for sdram_ack
// WAIT  | command accepted, waiting for data_rdy or watchdog expiry
module jtframe_sdram_arbiter
    import jtframe_sdram_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int SDRAMW  = 22,
    parameter int STARVE  = 15,
    parameter int TIMEOUT = 255
) (
    input logic rst,
    input logic clk,
    jtframe_sdram_arbiter_if.master bus
);

    localparam logic [WAIT_W-1:0] STARVE_C  = WAIT_W'(STARVE);
    localparam logic [WDOG_W-1:0] TIMEOUT_C = WDOG_W'(TIMEOUT);
    localparam logic [N-1:0]      LAST_RST  = {1'b1, {(N-1){1'b0}}};

    arb_state_t        state;
    logic [N-1:0]      cand, starved, rr_req, pick_st, pick_rr, win, last;
    logic [WAIT_W-1:0] wait_cnt [1:N-1];
    logic [WDOG_W-1:0] wdog;
    logic              issue;
    logic              win_rnw;
    logic [SDRAMW-1:0] win_addr;
    logic [15:0]       win_din;
    logic [1:0]        win_mask;

    // The granted slot and the slot whose done is pulsing are excluded, so a
    // completing request is never immediately re-granted.
    assign cand   = bus.slot_req & ~bus.slot_gnt & ~bus.slot_done;
    assign rr_req = {cand[N-1:1], 1'b0};

    always_comb begin
        starved = '0;
        for (int k = 1; k < N; k++)
            starved[k] = cand[k] && (wait_cnt[k] >= STARVE_C);
    end

    jtframe_rr_pick #(.N(N)) u_pick_starved (.req(starved), .last(last), .gnt(pick_st));
    jtframe_rr_pick #(.N(N)) u_pick_normal  (.req(rr_req),  .last(last), .gnt(pick_rr));

    always_comb begin
        if (|starved)     win = pick_st;
        else if (cand[0]) win = {{(N-1){1'b0}}, 1'b1};
        else              win = pick_rr;
    end

    // Arbitration happens in IDLE and on the completing edge in WAIT, which
    // gives back-to-back issue without an IDLE bubble.
    assign issue = (|cand) && ((state == ST_IDLE) || (state == ST_WAIT && bus.data_rdy));

    always_comb begin
        win_rnw  = 1'b1;
        win_addr = '0;
        win_din  = '0;
        win_mask = MASK_READ;
        for (int k = 0; k < N; k++)
            if (win[k]) begin
                win_rnw  = bus.slot_rnw[k];
                win_addr = bus.slot_addr[k*SDRAMW +: SDRAMW];
                win_din  = bus.slot_din[k*16 +: 16];
                win_mask = bus.slot_wrmask[k*2 +: 2];
            end
    end

    assign bus.slot_dst = {N{bus.data_dst}} & bus.slot_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < N; k++) wait_cnt[k] <= '0;
        end else begin
            for (int k = 1; k < N; k++) begin
                if (!bus.slot_req[k] || bus.slot_gnt[k] || (issue && win[k]))
                    wait_cnt[k] <= '0;
                else if (wait_cnt[k] < STARVE_C)
                    wait_cnt[k] <= wait_cnt[k] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            bus.slot_gnt     <= '0;
            bus.slot_done    <= '0;
            bus.sdram_rd     <= 1'b0;
            bus.sdram_wr     <= 1'b0;
            bus.sdram_addr   <= '0;
            bus.data_write   <= '0;
            bus.sdram_wrmask <= MASK_READ;
            bus.timeout_err  <= 1'b0;
            wdog             <= '0;
            last             <= LAST_RST;
        end else begin
            bus.slot_done <= '0;
            case (state)
                ST_IDLE: ;
                ST_ISSUE: begin
                    // data_rdy together with ack is deliberately ignored here
                    if (bus.sdram_ack) begin
                        bus.sdram_rd <= 1'b0;
                        bus.sdram_wr <= 1'b0;
                        wdog         <= TIMEOUT_C;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.data_rdy) begin
                        bus.slot_done <= bus.slot_gnt;
                        bus.slot_gnt  <= '0;
                        state         <= ST_IDLE;
                    end else if (wdog <= WDOG_W'(1)) begin
                        bus.slot_done   <= bus.slot_gnt;
                        bus.slot_gnt    <= '0;
                        bus.timeout_err <= 1'b1;
                        wdog            <= '0;
                        state           <= ST_IDLE;
                    end else begin
                        wdog <= wdog - WDOG_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Overrides the IDLE/clear-grant assignments above when a new
            // winner is taken on this edge.
            if (issue) begin
                state            <= ST_ISSUE;
                bus.slot_gnt     <= win;
                bus.sdram_rd     <= win_rnw;
                bus.sdram_wr     <= ~win_rnw;
                bus.sdram_addr   <= win_addr;
                bus.data_write   <= win_din;
                bus.sdram_wrmask <= win_rnw ? MASK_READ : win_mask;
                if (|win[N-1:1]) last <= win;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arbiter.sv
module tb_jtframe_sdram_arbiter;

    localparam int N  = 4;
    localparam int AW = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jtframe_sdram_arbiter_if #(.N(N), .SDRAMW(AW)) bus ();

    jtframe_sdram_arbiter #(.N(N), .SDRAMW(AW), .STARVE(15), .TIMEOUT(8)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus.master)
    );

    typedef struct {
        int          slot;
        logic        rnw;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  mask;
        int          ack_dly;
        int          rdy_dly;
        logic        exp_rd;
        logic        exp_wr;
        logic [1:0]  exp_mask;
        logic [3:0]  exp_gnt;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int s, input logic rnw, input logic [21:0] a,
                            input logic [15:0] d, input logic [1:0] m);
        bus.slot_rnw[s]           = rnw;
        bus.slot_addr[s*AW +: AW] = a;
        bus.slot_din[s*16 +: 16]  = d;
        bus.slot_wrmask[s*2 +: 2] = m;
    endtask

    task automatic ack_cycle();
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
    endtask

    task automatic rdy_cycle();
        bus.data_rdy = 1'b1;
        tick();
        bus.data_rdy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        set_slot(v.slot, v.rnw, v.addr, v.din, v.mask);
        bus.slot_req[v.slot] = 1'b1;
        tick();
        chk("issue_rd",   32'(bus.sdram_rd),     32'(v.exp_rd));
        chk("issue_wr",   32'(bus.sdram_wr),     32'(v.exp_wr));
        chk("issue_gnt",  32'(bus.slot_gnt),     32'(v.exp_gnt));
        chk("issue_addr", 32'(bus.sdram_addr),   32'(v.addr));
        chk("issue_data", 32'(bus.data_write),   32'(v.din));
        chk("issue_mask", 32'(bus.sdram_wrmask), 32'(v.exp_mask));
        for (int k = 1; k < v.ack_dly; k++) begin
            tick();
            chk("strobe_hold", 32'({bus.sdram_rd, bus.sdram_wr}), 32'({v.exp_rd, v.exp_wr}));
        end
        ack_cycle();
        chk("strobe_drop", 32'({bus.sdram_rd, bus.sdram_wr}), 32'd0);
        chk("wait_gnt",    32'(bus.slot_gnt), 32'(v.exp_gnt));
        for (int k = 1; k < v.rdy_dly; k++) tick();
        bus.data_rdy = 1'b1;
        bus.data_dst = 1'b1;
        #1;
        chk("slot_dst", 32'(bus.slot_dst), 32'(v.exp_gnt));
        tick();
        bus.data_rdy = 1'b0;
        bus.data_dst = 1'b0;
        chk("done_pulse", 32'(bus.slot_done), 32'(v.exp_gnt));
        chk("done_gnt",   32'(bus.slot_gnt),  32'd0);
        bus.slot_req[v.slot] = 1'b0;
        tick();
        chk("done_clear", 32'(bus.slot_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int order [6];
        order = '{1, 2, 3, 1, 2, 3};

        vecs[0] = '{2, 1'b1, 22'h001234, 16'h0000, 2'b00, 2, 5, 1'b1, 1'b0, 2'b11, 4'b0100};
        vecs[1] = '{0, 1'b0, 22'h000100, 16'hBEEF, 2'b01, 1, 3, 1'b0, 1'b1, 2'b01, 4'b0001};
        vecs[2] = '{1, 1'b0, 22'h3FFFFF, 16'h0001, 2'b10, 3, 7, 1'b0, 1'b1, 2'b10, 4'b0010};
        vecs[3] = '{3, 1'b1, 22'h2AAAAA, 16'h5A5A, 2'b00, 1, 1, 1'b1, 1'b0, 2'b11, 4'b1000};
        vecs[4] = '{0, 1'b1, 22'h000000, 16'hFFFF, 2'b10, 1, 2, 1'b1, 1'b0, 2'b11, 4'b0001};

        bus.slot_req    = '0;
        bus.slot_rnw    = '0;
        bus.slot_addr   = '0;
        bus.slot_din    = '0;
        bus.slot_wrmask = '0;
        bus.sdram_ack   = 1'b0;
        bus.data_rdy    = 1'b0;
        bus.data_dst    = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_gnt",  32'(bus.slot_gnt),     32'd0);
        chk("rst_done", 32'(bus.slot_done),    32'd0);
        chk("rst_cmd",  32'({bus.sdram_rd, bus.sdram_wr}), 32'd0);
        chk("rst_mask", 32'(bus.sdram_wrmask), 32'h3);
        chk("rst_addr", 32'(bus.sdram_addr),   32'd0);
        chk("rst_terr", 32'(bus.timeout_err),  32'd0);
        chk("rst_dst",  32'(bus.slot_dst),     32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // data_rdy while idle must not produce a done pulse
        rdy_cycle();
        chk("idle_rdy_done", 32'(bus.slot_done), 32'd0);
        chk("idle_rdy_cmd",  32'({bus.sdram_rd, bus.sdram_wr}), 32'd0);

        // round-robin among 1..3 with back-to-back issue
        for (int s = 1; s < 4; s++) set_slot(s, 1'b1, 22'(s), 16'h0, 2'b00);
        bus.slot_req = 4'b1110;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("rr_gnt",  32'(bus.slot_gnt),   32'(1 << order[i]));
            chk("rr_rd",   32'(bus.sdram_rd),   32'd1);
            chk("rr_addr", 32'(bus.sdram_addr), 32'(order[i]));
            ack_cycle();
            if (i == 5) bus.slot_req = '0;
            rdy_cycle();
            chk("rr_done", 32'(bus.slot_done), 32'(1 << order[i]));
        end
        chk("rr_end_gnt", 32'(bus.slot_gnt), 32'd0);
        tick();

        // slot 0 preferred over a fresh slot 3, then slot 3 gets its turn
        set_slot(1, 1'b1, 22'h11, 16'h0, 2'b00);
        set_slot(0, 1'b0, 22'h22, 16'h1111, 2'b00);
        set_slot(3, 1'b1, 22'h33, 16'h0, 2'b00);
        bus.slot_req[1] = 1'b1;
        tick();
        bus.slot_req[0] = 1'b1;
        bus.slot_req[3] = 1'b1;
        ack_cycle();
        rdy_cycle();
        bus.slot_req[1] = 1'b0;
        chk("pref_done", 32'(bus.slot_done), 32'b0010);
        chk("pref_slot0", 32'(bus.slot_gnt), 32'b0001);
        ack_cycle();
        rdy_cycle();
        bus.slot_req[0] = 1'b0;
        chk("pref_next", 32'(bus.slot_gnt), 32'b1000);
        ack_cycle();
        bus.slot_req[3] = 1'b0;
        rdy_cycle();
        chk("pref_s3_done", 32'(bus.slot_done), 32'b1000);
        tick();

        // slot 3 waits 20 cycles behind slot 1, then overrides slot 0
        bus.slot_req[1] = 1'b1;
        tick();
        bus.slot_req[0] = 1'b1;
        bus.slot_req[3] = 1'b1;
        repeat (20) tick();
        ack_cycle();
        rdy_cycle();
        bus.slot_req[1] = 1'b0;
        chk("starve_override", 32'(bus.slot_gnt), 32'b1000);
        ack_cycle();
        bus.slot_req[3] = 1'b0;
        rdy_cycle();
        chk("starve_s3_done", 32'(bus.slot_done), 32'b1000);
        chk("starve_then_s0", 32'(bus.slot_gnt),  32'b0001);
        ack_cycle();
        bus.slot_req[0] = 1'b0;
        rdy_cycle();
        chk("starve_s0_done", 32'(bus.slot_done), 32'b0001);
        tick();

        // ack and data_rdy together in ISSUE: ack taken, data_rdy ignored
        set_slot(2, 1'b1, 22'h44, 16'h0, 2'b00);
        bus.slot_req[2] = 1'b1;
        tick();
        bus.data_rdy = 1'b1;
        ack_cycle();
        bus.data_rdy = 1'b0;
        chk("ackrdy_done", 32'(bus.slot_done), 32'd0);
        chk("ackrdy_rd",   32'(bus.sdram_rd),  32'd0);
        chk("ackrdy_gnt",  32'(bus.slot_gnt),  32'b0100);
        rdy_cycle();
        bus.slot_req[2] = 1'b0;
        chk("ackrdy_later", 32'(bus.slot_done), 32'b0100);
        tick();

        // watchdog expiry 8 cycles after ack
        set_slot(2, 1'b1, 22'h77, 16'h0, 2'b00);
        bus.slot_req[2] = 1'b1;
        tick();
        ack_cycle();
        repeat (7) tick();
        chk("to_early_done", 32'(bus.slot_done),   32'd0);
        chk("to_early_err",  32'(bus.timeout_err), 32'd0);
        tick();
        bus.slot_req[2] = 1'b0;
        chk("to_done", 32'(bus.slot_done),   32'b0100);
        chk("to_err",  32'(bus.timeout_err), 32'd1);
        chk("to_gnt",  32'(bus.slot_gnt),    32'd0);
        tick();
        chk("to_done_clear", 32'(bus.slot_done), 32'd0);
        set_slot(1, 1'b0, 22'h99, 16'hCAFE, 2'b00);
        bus.slot_req[1] = 1'b1;
        tick();
        chk("to_next_wr",   32'(bus.sdram_wr),     32'd1);
        chk("to_next_gnt",  32'(bus.slot_gnt),     32'b0010);
        chk("to_next_data", 32'(bus.data_write),   32'hCAFE);
        chk("to_next_mask", 32'(bus.sdram_wrmask), 32'h0);
        ack_cycle();
        rdy_cycle();
        bus.slot_req[1] = 1'b0;
        chk("to_next_done", 32'(bus.slot_done), 32'b0010);
        tick();
        chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        // reset during WAIT, then RR pointer back to its reset position
        set_slot(2, 1'b1, 22'h123, 16'h0, 2'b00);
        bus.slot_req[2] = 1'b1;
        tick();
        ack_cycle();
        rst = 1'b1;
        #1;
        chk("rstw_gnt",  32'(bus.slot_gnt),     32'd0);
        chk("rstw_cmd",  32'({bus.sdram_rd, bus.sdram_wr}), 32'd0);
        chk("rstw_mask", 32'(bus.sdram_wrmask), 32'h3);
        chk("rstw_err",  32'(bus.timeout_err),  32'd0);
        bus.slot_req = '0;
        tick();
        tick();
        rst = 1'b0;
        set_slot(2, 1'b1, 22'h200, 16'h0, 2'b00);
        set_slot(3, 1'b1, 22'h300, 16'h0, 2'b00);
        bus.slot_req = 4'b1100;
        tick();
        chk("rstw_ptr_gnt", 32'(bus.slot_gnt),   32'b0100);
        chk("rstw_rd",      32'(bus.sdram_rd),   32'd1);
        chk("rstw_addr",    32'(bus.sdram_addr), 32'h200);
        ack_cycle();
        rdy_cycle();
        bus.slot_req[2] = 1'b0;
        chk("rstw_done2", 32'(bus.slot_done), 32'b0100);
        chk("rstw_next3", 32'(bus.slot_gnt),  32'b1000);
        ack_cycle();
        bus.slot_req[3] = 1'b0;
        rdy_cycle();
        chk("rstw_done3", 32'(bus.slot_done), 32'b1000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
